peripheral_ahb32apb4: RTL and testbench
=======================================

// Module: peripheral_ahb32apb4
// PURPOSE
// - APB4 slave to AHB3-Lite master bridge; reverse path of the AHB3->APB4 bridge used in front of peripheral_gpio_apb4.
// - An APB4 requester (debug/boot controller, DMA config port) issues single accesses that are re-issued on the AHB3-Lite bus.
// - One outstanding transfer at a time; AHB side is SINGLE/NONSEQ only. One clock domain; no CDC.
// PARAMETERS
// - HADDR_SIZE  32           AHB address width
// - HDATA_SIZE  32           AHB data width; must equal PDATA_SIZE (8/16/32/64)
// - PADDR_SIZE  10           APB address width; must be <= HADDR_SIZE
// - PDATA_SIZE  32           APB data width
// - BASE_ADDR   32'h0000_0000  added to zero-extended PADDR to form HADDR (modulo 2^HADDR_SIZE)
// PORTS
// - HCLK       in   1             single clock for both sides
// - HRESET     in   1             synchronous, active-high reset
// - PSEL       in   1             APB select
// - PENABLE    in   1             APB access phase
// - PADDR      in   PADDR_SIZE    APB byte address
// - PWRITE     in   1             1=write
// - PWDATA     in   PDATA_SIZE    write data
// - PSTRB      in   PDATA_SIZE/8  write byte strobes
// - PPROT      in   3             APB protection
// - PRDATA     out  PDATA_SIZE    read data; valid while PREADY=1 on a read
// - PREADY     out  1             access complete
// - PSLVERR    out  1             error; valid only while PREADY=1
// - HADDR      out  HADDR_SIZE    AHB address
// - HWRITE     out  1             AHB direction
// - HSIZE      out  3             fixed log2(HDATA_SIZE/8)
// - HBURST     out  3             fixed 3'b000 (SINGLE)
// - HPROT      out  4             from PPROT
// - HTRANS     out  2             IDLE=2'b00, NONSEQ=2'b10
// - HMASTLOCK  out  1             fixed 0
// - HWDATA     out  HDATA_SIZE    write data, driven in data phase
// - HRDATA     in   HDATA_SIZE    read data
// - HREADY     in   1             AHB ready (bus-level)
// - HRESP      in   1             0=OKAY, 1=ERROR
// BEHAVIOUR
// - Reset (sync, HRESET=1 at edge): state=IDLE; HTRANS=IDLE; HADDR/HWDATA/HWRITE/HPROT/PRDATA=0; PREADY=0; PSLVERR=0.
// - All outputs registered. PREADY pulses exactly 1 cycle per access.
// - FSM IDLE: on PSEL=1,PENABLE=0 (setup) latch PADDR/PWRITE/PWDATA/PSTRB/PPROT, then check:
//   - PADDR[log2(PDATA_SIZE/8)-1:0]!=0 (misaligned) or (PWRITE && PSTRB!=all-ones) -> RESP with PSLVERR=1; no AHB transfer.
//   - else -> ADDR.
// - ADDR: HTRANS=NONSEQ, HADDR=BASE_ADDR+PADDR, HWRITE, HPROT valid. Held while HREADY=0; HREADY=1 -> DATA.
// - DATA: HTRANS=IDLE; HWDATA=latched PWDATA (writes). Wait while HREADY=0.
//   - HREADY=1,HRESP=0 -> RESP, PRDATA<=HRDATA (reads), PSLVERR=0.
//   - HREADY=1,HRESP=1 -> RESP, PSLVERR=1, PRDATA=0. First ERROR cycle (HREADY=0,HRESP=1) is just a wait.
// - RESP: PREADY=1 for one cycle -> IDLE; PREADY,PSLVERR,PRDATA clear the next cycle.
// - Zero-wait latency: setup sampled at edge E0; NONSEQ E1..E2; data phase E2..E3; PREADY=1 E3..E4. Each AHB wait state adds 1.
// - Back-to-back: next setup is accepted in the cycle after RESP; no AHB NONSEQ is issued during a data phase.
// - HPROT = {1'b0 cacheable, 1'b0 bufferable, PPROT[0] privileged, ~PPROT[2] data}.
// - HADDR addition wraps modulo 2^HADDR_SIZE; no overflow flag.
// - PSEL dropped before PREADY (protocol violation): the AHB transfer still completes; the result is discarded and PREADY is still pulsed.
// - Reset mid-transfer: next cycle HTRANS=IDLE and all outputs take reset values; the APB access is abandoned.
// TESTING
// - Write PADDR=0x010, PWDATA=0xA5A5_5A5A, PSTRB=4'hF, BASE=0x4000_0000, HREADY=1 -> HADDR=0x4000_0010 NONSEQ 1 cycle, HWDATA=0xA5A5_5A5A; PREADY 3 cycles after setup; PSLVERR=0.
// - Read PADDR=0x004; slave adds 2 wait states, HRDATA=0x1234_5678 -> PREADY 5 cycles after setup; PRDATA=0x1234_5678.
// - Read with 2-cycle ERROR response -> PSLVERR=1 with PREADY, PRDATA=0; HTRANS stays IDLE after the address phase.
// - Write PSTRB=4'b0011, then read PADDR=0x002 -> each gets PREADY+PSLVERR 2 cycles after setup; HTRANS never leaves IDLE.
// - HRESET asserted during DATA with HREADY=0 -> next cycle HTRANS=IDLE, PREADY=0; a new write then completes normally.
// - Back-to-back write then read, same address -> exactly two NONSEQ cycles; read returns the written data from the memory model.

Source files
------------

// File: rtl/peripheral_ahb32apb4.sv
// rtl/peripheral_ahb32apb4.sv - APB4 slave to AHB3-Lite master bridge, one outstanding SINGLE transfer
module peripheral_ahb32apb4 #(
  parameter int                    HADDR_SIZE = 32,
  parameter int                    HDATA_SIZE = 32,
  parameter int                    PADDR_SIZE = 10,
  parameter int                    PDATA_SIZE = 32,
  parameter logic [HADDR_SIZE-1:0] BASE_ADDR  = '0
) (
  input  logic                    i_hclk,
  input  logic                    i_hreset,
  input  logic                    i_psel,
  input  logic                    i_penable,
  input  logic [PADDR_SIZE-1:0]   i_paddr,
  input  logic                    i_pwrite,
  input  logic [PDATA_SIZE-1:0]   i_pwdata,
  input  logic [PDATA_SIZE/8-1:0] i_pstrb,
  input  logic [2:0]              i_pprot,
  output logic [PDATA_SIZE-1:0]   o_prdata,
  output logic                    o_pready,
  output logic                    o_pslverr,
  output logic [HADDR_SIZE-1:0]   o_haddr,
  output logic                    o_hwrite,
  output logic [2:0]              o_hsize,
  output logic [2:0]              o_hburst,
  output logic [3:0]              o_hprot,
  output logic [1:0]              o_htrans,
  output logic                    o_hmastlock,
  output logic [HDATA_SIZE-1:0]   o_hwdata,
  input  logic [HDATA_SIZE-1:0]   i_hrdata,
  input  logic                    i_hready,
  input  logic                    i_hresp
);

  localparam int                    STRB_W        = PDATA_SIZE / 8;
  localparam int                    ALIGN_W       = $clog2(STRB_W);
  localparam logic [PADDR_SIZE-1:0] ALIGN_MASK    = PADDR_SIZE'((1 << ALIGN_W) - 1);
  localparam logic [1:0]            HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]            HTRANS_NONSEQ = 2'b10;

  // DECODE spends the APB access-phase cycle checking the latched request;
  // REJECT delays the error response so it lines up with a normal PREADY slot.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_REJECT,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_t;

  state_t                  r_state;
  logic [PADDR_SIZE-1:0]   r_paddr;
  logic                    r_pwrite;
  logic [PDATA_SIZE-1:0]   r_pwdata;
  logic [STRB_W-1:0]       r_pstrb;
  logic [1:0]              r_pprot;
  logic [PDATA_SIZE-1:0]   r_prdata;
  logic                    r_pready;
  logic                    r_pslverr;
  logic [HADDR_SIZE-1:0]   r_haddr;
  logic                    r_hwrite;
  logic [3:0]              r_hprot;
  logic [1:0]              r_htrans;
  logic [HDATA_SIZE-1:0]   r_hwdata;

  logic                    w_misaligned;
  logic                    w_bad_strb;
  logic [HADDR_SIZE-1:0]   w_haddr;
  logic                    w_unused_pprot;

  assign w_misaligned   = |(r_paddr & ALIGN_MASK);
  assign w_bad_strb     = r_pwrite && (r_pstrb != {STRB_W{1'b1}});
  assign w_haddr        = BASE_ADDR + HADDR_SIZE'(r_paddr);
  assign w_unused_pprot = i_pprot[1];

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      r_state   <= ST_IDLE;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_pprot   <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_haddr   <= '0;
      r_hwrite  <= 1'b0;
      r_hprot   <= '0;
      r_htrans  <= HTRANS_IDLE;
      r_hwdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_psel && !i_penable) begin
            r_paddr  <= i_paddr;
            r_pwrite <= i_pwrite;
            r_pwdata <= i_pwdata;
            r_pstrb  <= i_pstrb;
            r_pprot  <= {i_pprot[2], i_pprot[0]};
            r_state  <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (w_misaligned || w_bad_strb) begin
            r_state <= ST_REJECT;
          end else begin
            r_htrans <= HTRANS_NONSEQ;
            r_haddr  <= w_haddr;
            r_hwrite <= r_pwrite;
            r_hprot  <= {2'b00, r_pprot[0], ~r_pprot[1]};
            r_state  <= ST_ADDR;
          end
        end
        ST_REJECT: begin
          r_pready  <= 1'b1;
          r_pslverr <= 1'b1;
          r_prdata  <= '0;
          r_state   <= ST_RESP;
        end
        ST_ADDR: begin
          if (i_hready) begin
            r_htrans <= HTRANS_IDLE;
            if (r_hwrite) begin
              r_hwdata <= r_pwdata;
            end
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          // HREADY low with HRESP high is the first ERROR cycle: keep waiting.
          if (i_hready) begin
            r_pready  <= 1'b1;
            r_pslverr <= i_hresp;
            r_prdata  <= (!i_hresp && !r_hwrite) ? i_hrdata : '0;
            r_state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          r_prdata  <= '0;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_prdata    = r_prdata;
  assign o_pready    = r_pready;
  assign o_pslverr   = r_pslverr;
  assign o_haddr     = r_haddr;
  assign o_hwrite    = r_hwrite;
  assign o_hsize     = 3'($clog2(HDATA_SIZE / 8));
  assign o_hburst    = 3'b000;
  assign o_hprot     = r_hprot;
  assign o_htrans    = r_htrans;
  assign o_hmastlock = 1'b0;
  assign o_hwdata    = r_hwdata;

endmodule

// File: tb/tb_peripheral_ahb32apb4.sv
// tb/tb_peripheral_ahb32apb4.sv - directed and random APB accesses against an AHB slave and reference memory
module tb_peripheral_ahb32apb4;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        hreset;
  logic        psel, penable, pwrite;
  logic [9:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hmastlock;
  logic [31:0] hwdata, hrdata;
  logic        hready, hresp;

  int checks = 0;
  int errors = 0;

  logic [31:0] slv_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  always #5 clk = ~clk;

  peripheral_ahb32apb4 #(
    .HADDR_SIZE(32), .HDATA_SIZE(32), .PADDR_SIZE(10), .PDATA_SIZE(32), .BASE_ADDR(BASE)
  ) dut (
    .i_hclk(clk), .i_hreset(hreset),
    .i_psel(psel), .i_penable(penable), .i_paddr(paddr), .i_pwrite(pwrite),
    .i_pwdata(pwdata), .i_pstrb(pstrb), .i_pprot(pprot),
    .o_prdata(prdata), .o_pready(pready), .o_pslverr(pslverr),
    .o_haddr(haddr), .o_hwrite(hwrite), .o_hsize(hsize), .o_hburst(hburst),
    .o_hprot(hprot), .o_htrans(htrans), .o_hmastlock(hmastlock), .o_hwdata(hwdata),
    .i_hrdata(hrdata), .i_hready(hready), .i_hresp(hresp)
  );

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5EED_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One APB access; the task also plays the AHB slave cycle by cycle.
  task automatic access(input logic wr, input logic [9:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic [2:0] pr, input int aw,
                        input int w, input logic er, input logic drop, output int nonseq);
    int          lat, waits_left, aw_left;
    logic        got, in_data, viol, se, cap_wr, rej;
    logic [31:0] rd, cap_addr, cap_wdata, ea, exp_rd;
    logic [3:0]  cap_prot;
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st; pprot = pr;
    hready = 1; hresp = 0;
    @(posedge clk); #1;
    penable = 1;
    if (drop) begin psel = 0; penable = 0; end
    nonseq = 0; got = 0; in_data = 0; aw_left = aw; waits_left = 0; viol = 0; lat = 0;
    rd = '0; se = 0; cap_wr = 0; cap_addr = '0; cap_wdata = '0; cap_prot = '0;
    for (int k = 1; k <= 60 && !got; k++) begin
      @(posedge clk); #1;
      hrdata = $urandom;
      if (htrans == 2'b10) begin
        nonseq++;
        if (in_data) viol = 1;
      end
      if (pready) begin
        got = 1; lat = k; rd = prdata; se = pslverr; hready = 1; hresp = 0;
      end else if (in_data) begin
        if (waits_left > 0) begin
          hready = 0; hresp = er && (waits_left == 1); waits_left--;
        end else begin
          hready = 1; hresp = er; in_data = 0; cap_wdata = hwdata;
          if (!er && cap_wr) slv_mem[cap_addr] = hwdata;
          else if (!er) hrdata = slv_mem.exists(cap_addr) ? slv_mem[cap_addr] : dflt(cap_addr);
        end
      end else if (htrans == 2'b10) begin
        cap_addr = haddr; cap_wr = hwrite; cap_prot = hprot;
        if (aw_left > 0) begin hready = 0; hresp = 0; aw_left--; end
        else begin hready = 1; hresp = 0; in_data = 1; waits_left = w; end
      end else begin
        hready = 1; hresp = 0;
      end
    end
    check("pready_seen", 64'(got), 64'd1);
    if (got) begin
      @(posedge clk); #1;
      check("pready_pulse", 64'(pready), 64'd0);
    end
    psel = 0; penable = 0;

    rej = (a[1:0] != 2'b00) || (wr && st != 4'hF);
    ea  = BASE + {22'b0, a};
    check("latency", 64'(lat), rej ? 64'd2 : 64'(3 + aw + w));
    check("nonseq_cycles", 64'(nonseq), rej ? 64'd0 : 64'(1 + aw));
    check("nonseq_in_data", 64'(viol), 64'd0);
    if (!drop) begin
      exp_rd = (!wr && !rej && !er) ? (ref_mem.exists(ea) ? ref_mem[ea] : dflt(ea)) : 32'h0;
      check("pslverr", 64'(se), 64'(rej || er));
      check("prdata", 64'(rd), 64'(exp_rd));
    end
    if (!rej) begin
      check("haddr", 64'(cap_addr), 64'(ea));
      check("hwrite", 64'(cap_wr), 64'(wr));
      check("hprot", 64'(cap_prot), 64'({2'b00, pr[0], ~pr[2]}));
      if (wr) check("hwdata", 64'(cap_wdata), 64'(wd));
      if (wr && !er) ref_mem[ea] = wd;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int          ns, ns2, aw, w;
    logic        wr, er;
    logic [9:0]  a;
    logic [3:0]  st;

    hreset = 1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0;
    pprot = '0; hrdata = '0; hready = 1; hresp = 0;
    slv_mem[BASE + 32'h4] = 32'h1234_5678;
    ref_mem[BASE + 32'h4] = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1;
    check("rst_htrans", 64'(htrans), 64'd0);
    check("rst_pready", 64'(pready), 64'd0);
    check("rst_pslverr", 64'(pslverr), 64'd0);
    check("rst_prdata", 64'(prdata), 64'd0);
    check("rst_haddr", 64'(haddr), 64'd0);
    check("rst_hwdata", 64'(hwdata), 64'd0);
    check("rst_hwrite", 64'(hwrite), 64'd0);
    check("rst_hprot", 64'(hprot), 64'd0);
    check("hsize", 64'(hsize), 64'd2);
    check("hburst", 64'(hburst), 64'd0);
    check("hmastlock", 64'(hmastlock), 64'd0);
    hreset = 0;
    @(posedge clk); #1;

    access(1, 10'h010, 32'hA5A5_5A5A, 4'hF, 3'b000, 0, 0, 0, 0, ns);
    access(0, 10'h004, 32'h0, 4'h0, 3'b001, 0, 2, 0, 0, ns);
    access(0, 10'h008, 32'h0, 4'h0, 3'b100, 0, 1, 1, 0, ns);
    access(1, 10'h00C, 32'hDEAD_BEEF, 4'b0011, 3'b000, 0, 0, 0, 0, ns);
    access(0, 10'h002, 32'h0, 4'h0, 3'b000, 0, 0, 0, 0, ns);
    access(1, 10'h014, 32'hCAFE_0001, 4'hF, 3'b101, 1, 0, 0, 0, ns);

    // Reset while the data phase is stalled.
    psel = 1; penable = 0; pwrite = 0; paddr = 10'h020; pstrb = 4'h0; hready = 1; hresp = 0;
    @(posedge clk); #1;
    penable = 1;
    @(posedge clk); #1;
    check("rst_mid_nonseq", 64'(htrans), 64'd2);
    @(posedge clk); #1;
    check("rst_mid_data_idle", 64'(htrans), 64'd0);
    hready = 0; hreset = 1;
    @(posedge clk); #1;
    check("rst_mid_htrans", 64'(htrans), 64'd0);
    check("rst_mid_pready", 64'(pready), 64'd0);
    check("rst_mid_haddr", 64'(haddr), 64'd0);
    hreset = 0; psel = 0; penable = 0; hready = 1;
    @(posedge clk); #1;
    access(1, 10'h030, 32'h0BAD_F00D, 4'hF, 3'b010, 0, 0, 0, 0, ns);

    // Back-to-back write then read of the same location.
    access(1, 10'h040, 32'h7654_3210, 4'hF, 3'b000, 0, 0, 0, 0, ns);
    access(0, 10'h040, 32'h0, 4'h0, 3'b000, 0, 0, 0, 0, ns2);
    check("b2b_nonseq_total", 64'(ns + ns2), 64'd2);

    // Requester drops PSEL during the access; transfer still runs to PREADY.
    access(1, 10'h044, 32'h1111_2222, 4'hF, 3'b000, 0, 1, 0, 1, ns);

    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom);
      a  = {4'b0, 4'($urandom), ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
      st = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      er = ($urandom_range(0, 5) == 0);
      aw = $urandom_range(0, 1);
      w  = $urandom_range(0, 3);
      if (er && w == 0) w = 1;
      access(wr, a, $urandom, st, 3'($urandom), aw, w, er, 0, ns);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
